program_loader: RTL

Byte-stream writer that fills the processor's instruction memory before execution starts. It sits beside the pipelined processor, receives a framed program image over a valid/ready byte interface, assembles 32-bit big-endian words and writes them to sequential instruction-memory addresses. It holds the processor stalled until a frame with a correct checksum completes.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_word_assembler.sv | 35 +++
 rtl/program_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
// The loader FSM and the word assembler both import this package.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam logic [1:0] LAST_BYTE_INDEX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs incoming bytes MSB-first into a 32-bit word and flags the byte that completes it.
// A sync byte clears any partially assembled word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_shiftEn,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_wordReady
);

    logic [31:0] r_shift;
    logic [1:0]  r_index;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= 32'd0;
            r_index <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 32'd0;
            r_index <= 2'd0;
        end else if (i_shiftEn) begin
            r_shift <= {r_shift[23:0], i_byte};
            r_index <= r_index + 2'd1;
        end
    end

    // High during the cycle whose accepted byte completes the word.
    assign o_wordReady = i_shiftEn && (r_index == LAST_BYTE_INDEX);
    assign o_word      = r_shift;

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image over a valid/ready byte stream, writes big-endian words
// to sequential instruction-memory addresses and stalls the CPU until a good checksum arrives.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byteValid,
    input  logic [7:0]            byteData,
    output logic                  byteReady,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [ADDR_WIDTH-1:0] wordCount
);

    loader_state_t         r_state;
    loader_state_t         w_nextState;
    logic                  r_running;
    logic [ADDR_WIDTH-1:0] r_memAddress;
    logic [ADDR_WIDTH-1:0] r_wordCount;
    logic [7:0]            r_wordsLeft;
    logic [7:0]            r_checksum;
    logic                  w_accept;
    logic                  w_waitingForSync;
    logic                  w_syncStart;
    logic                  w_shiftEn;
    logic                  w_wordReady;
    logic [7:0]            w_checkSum;

    // r_running keeps byteReady low until the first edge after reset release.
    assign byteReady        = r_running && (r_state != ST_WRITE);
    assign w_accept         = byteValid && byteReady;
    assign w_waitingForSync = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_syncStart      = w_accept && w_waitingForSync && (byteData == SYNC_BYTE);
    assign w_shiftEn        = w_accept && (r_state == ST_DATA);
    assign w_checkSum       = r_checksum + byteData;

    word_assembler u_wordAssembler (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_syncStart),
        .i_shiftEn   (w_shiftEn),
        .i_byte      (byteData),
        .o_word      (memWriteData),
        .o_wordReady (w_wordReady)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        memWrite    = 1'b0;
        cpuHold     = 1'b1;
        loadDone    = 1'b0;
        loadError   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_syncStart) w_nextState = ST_LEN;
            end
            ST_LEN: begin
                if (w_accept) w_nextState = (byteData == 8'd0) ? ST_ERROR : ST_DATA;
            end
            ST_DATA: begin
                if (w_wordReady) w_nextState = ST_WRITE;
            end
            ST_WRITE: begin
                memWrite    = 1'b1;
                w_nextState = (r_wordsLeft == 8'd1) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (w_accept) w_nextState = (w_checkSum == 8'd0) ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                cpuHold  = 1'b0;
                loadDone = 1'b1;
                if (w_syncStart) w_nextState = ST_LEN;
            end
            ST_ERROR: begin
                loadError = 1'b1;
                if (w_syncStart) w_nextState = ST_LEN;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Address, word count and checksum restart on every accepted frame sync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_running    <= 1'b0;
            r_memAddress <= '0;
            r_wordCount  <= '0;
            r_wordsLeft  <= 8'd0;
            r_checksum   <= 8'd0;
        end else begin
            r_running <= 1'b1;
            if (w_syncStart) begin
                r_memAddress <= '0;
                r_wordCount  <= '0;
                r_checksum   <= 8'd0;
            end
            if (w_accept && (r_state == ST_LEN)) begin
                r_wordsLeft <= byteData;
            end
            if (w_shiftEn) begin
                r_checksum <= w_checkSum;
            end
            if (r_state == ST_WRITE) begin
                r_memAddress <= r_memAddress + ADDR_WIDTH'(1);
                r_wordCount  <= r_wordCount + ADDR_WIDTH'(1);
                r_wordsLeft  <= r_wordsLeft - 8'd1;
            end
        end
    end

    assign memAddress = r_memAddress;
    assign wordCount  = r_wordCount;

endmodule
